// File: rtl/top_fdct_mac_pipe_if.sv
// rtl/top_fdct_mac_pipe_if.sv - sample/coefficient stream and result bus for the fdct MAC lane
interface top_fdct_mac_pipe_if #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 15,
  parameter int dout_WIDTH = 16
);
  logic                  ce;
  logic                  in_valid;
  logic                  acc_clr;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic [dout_WIDTH-1:0] dout;

  modport master (
    output ce, in_valid, acc_clr, din0, din1,
    input  out_valid, dout
  );

  modport slave (
    input  ce, in_valid, acc_clr, din0, din1,
    output out_valid, dout
  );
endinterface

// File: rtl/top_fdct_mac_pipe.sv
// rtl/top_fdct_mac_pipe.sv - pipelined MAC, round/shift/narrow per group of N_TAPS products
// Optional saturating narrowing: define TOP_FDCT_MAC_SAT_EN.
module top_fdct_mac_pipe #(
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 15,
  parameter int B_SIGNED   = 0,
  parameter int NUM_STAGE  = 3,
  parameter int N_TAPS     = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int SHIFT      = 13,
  parameter int dout_WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  top_fdct_mac_pipe_if.slave bus
);
  localparam int P  = din0_WIDTH + din1_WIDTH + 1;
  localparam int CW = $clog2(N_TAPS) + 1;
  localparam int LS = NUM_STAGE - 1;
  localparam logic [CW-1:0]        L_LAST = CW'(N_TAPS);
  localparam logic [ACC_WIDTH-1:0] L_HALF = {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SHIFT - 1);

  if (ACC_WIDTH < P + $clog2(N_TAPS)) begin : g_acc_chk
    $error("top_fdct_mac_pipe: ACC_WIDTH too small for P + clog2(N_TAPS)");
  end
  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_stage_chk
    $error("top_fdct_mac_pipe: NUM_STAGE must be 1..4");
  end
  if (N_TAPS < 2 || N_TAPS > 64) begin : g_taps_chk
    $error("top_fdct_mac_pipe: N_TAPS must be 2..64");
  end
  if (SHIFT < 1 || SHIFT > ACC_WIDTH - dout_WIDTH) begin : g_shift_chk
    $error("top_fdct_mac_pipe: SHIFT out of range");
  end

  logic                        w_b_msb;
  logic signed [P-1:0]         w_a;
  logic signed [P-1:0]         w_b;
  logic signed [P-1:0]         w_prod;
  logic signed [P-1:0]         r_prod [NUM_STAGE];
  logic [NUM_STAGE-1:0]        r_vld;
  logic [NUM_STAGE-1:0]        r_clr;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_p_ext;
  logic signed [ACC_WIDTH-1:0] w_base;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] w_rnd;
  logic signed [ACC_WIDTH-1:0] w_shr;
  logic [CW-1:0]               r_tap;
  logic [CW-1:0]               w_tap_nxt;
  logic                        w_restart;
  logic                        w_fire;
  logic [dout_WIDTH-1:0]       w_narrow;
  logic [dout_WIDTH-1:0]       r_dout;
  logic                        r_out_valid;

  // Unsigned din1 gets a zero top bit so one signed multiplier serves both modes.
  assign w_b_msb = (B_SIGNED != 0) & bus.din1[din1_WIDTH-1];
  assign w_a     = {{(P-din0_WIDTH){bus.din0[din0_WIDTH-1]}}, bus.din0};
  assign w_b     = {{(P-din1_WIDTH){w_b_msb}}, bus.din1};
  assign w_prod  = w_a * w_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_clr <= '0;
      for (int i = 0; i < NUM_STAGE; i++) r_prod[i] <= '0;
    end else if (bus.ce) begin
      r_vld[0]  <= bus.in_valid;
      r_clr[0]  <= bus.acc_clr;
      r_prod[0] <= w_prod;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_clr[i]  <= r_clr[i-1];
        r_prod[i] <= r_prod[i-1];
      end
    end
  end

  assign w_p_ext   = {{(ACC_WIDTH-P){r_prod[LS][P-1]}}, r_prod[LS]};
  assign w_restart = (r_tap == '0) | r_clr[LS];
  assign w_base    = w_restart ? '0 : r_acc;
  assign w_sum     = w_base + w_p_ext;
  assign w_tap_nxt = w_restart ? CW'(1) : r_tap + 1'b1;
  assign w_fire    = r_vld[LS] & (w_tap_nxt == L_LAST);
  assign w_rnd     = w_sum + L_HALF;
  assign w_shr     = w_rnd >>> SHIFT;

`ifdef TOP_FDCT_MAC_SAT_EN
  logic w_fits;
  // Value fits when every bit from the output sign bit upward agrees.
  assign w_fits   = (&w_shr[ACC_WIDTH-1:dout_WIDTH-1]) | ~(|w_shr[ACC_WIDTH-1:dout_WIDTH-1]);
  assign w_narrow = w_fits ? w_shr[dout_WIDTH-1:0]
                  : (w_shr[ACC_WIDTH-1] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                        : {1'b0, {(dout_WIDTH-1){1'b1}}});
`else
  logic w_unused_hi;
  assign w_unused_hi = &{1'b0, w_shr[ACC_WIDTH-1:dout_WIDTH]};
  assign w_narrow    = w_shr[dout_WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_tap       <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else if (bus.ce) begin
      r_out_valid <= 1'b0;
      if (r_vld[LS]) begin
        if (w_fire) begin
          r_acc       <= '0;
          r_tap       <= '0;
          r_dout      <= w_narrow;
          r_out_valid <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_tap <= w_tap_nxt;
        end
      end else if (r_clr[LS]) begin
        r_acc <= '0;
        r_tap <= '0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
endmodule

// File: tb/tb_top_fdct_mac_pipe.sv
// tb/tb_top_fdct_mac_pipe.sv - scoreboard bench for top_fdct_mac_pipe (default parameters)
module tb_top_fdct_mac_pipe;
  typedef struct {
    int d;
    int cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  logic ce_prev;
  exp_t sb_q[$];

  top_fdct_mac_pipe_if #(.din0_WIDTH(16), .din1_WIDTH(15), .dout_WIDTH(16)) bus ();

  top_fdct_mac_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // A held out_valid during ce=0 is the same pulse, so only count it after an enabled edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && ce_prev) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_pulse: got out_valid at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("dout", int'($signed(bus.dout)), e.d);
        chk("out_cycle", cyc, e.cyc);
      end
    end
    ce_prev = bus.ce;
  end

  task automatic drive(input logic v, input logic c, input logic e, input int a, input int b);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.acc_clr  = c;
    bus.ce       = e;
    bus.din0     = 16'(a);
    bus.din1     = 15'(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic push(input int d, input int c);
    exp_t e;
    e.d   = d;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic group(input int a, input int b, input int d);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, a, b);
      if (i == 7) push(d, cyc + 4);
    end
  endtask

  initial begin
    int first;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    ce_prev = 1'b0;
    reset = 1'b1;
    bus.ce = 1'b0;
    bus.in_valid = 1'b0;
    bus.acc_clr = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    @(negedge clk);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_dout", int'($signed(bus.dout)), 0);

    group(1000, 8192, 8000);
    idle(6);

    group(1, 512, 1);
    group(-1, 512, 0);
    idle(6);

`ifdef TOP_FDCT_MAC_SAT_EN
    group(-32768, 32767, -32768);
`else
    group(-32768, 32767, 32);
`endif
    idle(6);

    drive(1'b1, 1'b0, 1'b1, 1000, 8192);
    first = cyc;
    for (int i = 1; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 1000, 8192);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 77, 99);
    push(8000, first + 7 + 4 + 3);
    for (int i = 5; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 1000, 8192);
    idle(8);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1000, 8192);
    drive(1'b1, 1'b1, 1'b1, 1000, 8192);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1000, 8192);
      if (i == 6) push(8000, cyc + 4);
    end
    idle(6);

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1000, 8192);
    drive(1'b0, 1'b1, 1'b1, 0, 0);
    idle(8);
    group(1000, 8192, 8000);
    idle(6);

    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1000, 8192);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_async_out_valid", int'(bus.out_valid), 0);
    chk("rst_async_dout", int'($signed(bus.dout)), 0);
    @(negedge clk);
    reset = 1'b0;
    group(1000, 8192, 8000);
    idle(8);

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/top_fdct_mac_pipe.md
# top_fdct_mac_pipe

Parametrised, pipelined signed multiply-accumulate unit for the fdct datapath. It is the successor to the single-cycle combinational 16s×15ns multiplier. It multiplies a signed coefficient operand by a signed or unsigned sample operand through a configurable-depth register pipeline, then accumulates a fixed number of products per output. Each sum is rounded, shifted and narrowed to a single output word. It sits between the fdct coefficient/sample fetch and the row/column transpose buffer, one instance per DCT output lane.

## Interface
- din0_WIDTH, 16: width of din0, always signed.
- din1_WIDTH, 15: width of din1.
- B_SIGNED, 0: 1 = din1 is signed; 0 = din1 is unsigned (zero-extended by one bit).
- NUM_STAGE, 3: multiplier pipeline registers, 1..4.
- N_TAPS, 8: products summed per output, 2..64.
- ACC_WIDTH, 40: accumulator width. Must be ≥ din0_WIDTH+din1_WIDTH+1+clog2(N_TAPS), otherwise an elaboration-time error is raised.
- SHIFT, 13: right shift applied to the sum, 1..ACC_WIDTH-dout_WIDTH.
- dout_WIDTH, 16: output width, signed.
- clk  in  1: clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- ce  in  1: clock enable. Low freezes every register.
- in_valid  in  1: din0/din1/acc_clr qualify this cycle.
- acc_clr  in  1: start a new accumulation group (sideband).
- din0  in  din0_WIDTH: signed operand.
- din1  in  din1_WIDTH: second operand.
- out_valid  out  1: one-cycle pulse, dout valid.
- dout  out  dout_WIDTH: rounded, narrowed sum.

## Operation
- Product width is P = din0_WIDTH+din1_WIDTH+1 (+1 covers the unsigned extension). The product is full precision, with no truncation.
- Pipeline: the product, its valid flag and acc_clr travel together through NUM_STAGE registers. A cycle with in_valid=0 is a bubble and is not counted.
- Accumulate stage, on a valid product:
  - If tap_cnt==0 or clr is set: acc ← sign-extended product, tap_cnt ← 1.
  - Otherwise: acc ← acc + product, tap_cnt ← tap_cnt+1.
- Group completion: when the product makes tap_cnt reach N_TAPS:
  - The final sum (acc + product) is rounded: add 1<<(SHIFT-1), then arithmetic shift right by SHIFT. This is round-half-up.
  - The result is narrowed to dout_WIDTH and registered to dout with out_valid=1.
  - tap_cnt wraps to 0.
- acc_clr with in_valid=0 inserts a clear token. At the accumulate stage it discards the partial sum, sets tap_cnt ← 0 and produces no output.
- acc_clr with in_valid=1 discards any partial group. That sample becomes tap 1 of a new group.
- Partial groups never emit output.
- dout holds its last value until the next group completes. out_valid is high for exactly one ce-enabled cycle per group.

## Timing
- Reset: all pipeline valid/clr bits 0, acc 0, tap_cnt 0, out_valid 0, dout 0. Reset takes effect immediately and asynchronously at any point in a group; in-flight products are lost.
- Latency from the N_TAPS-th accepted input to out_valid is NUM_STAGE+1 ce-enabled cycles.
- Throughput is one input per cycle, with no back-pressure. The consumer must accept every out_valid pulse.
- ce=0: all registers, including tap_cnt and out_valid, hold their values. A held out_valid=1 stays high while ce=0 and counts as one pulse. Inputs presented while ce=0 are ignored.
- Back-to-back groups are supported. The first tap of group k+1 may be accepted the cycle after the last tap of group k.

## Configuration
- TOP_FDCT_MAC_SAT_EN defined: narrowing saturates to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
- TOP_FDCT_MAC_SAT_EN undefined: narrowing keeps the low dout_WIDTH bits (two's-complement wrap).
- The macro affects the narrowing stage only. Latency is identical in both builds.

## Test plan
All cases use defaults except where stated.
- Unity gain: 8 × (din0=1000, din1=8192) contiguous, ce=1 → one out_valid pulse 4 cycles after the 8th input, dout=8000.
- Rounding:
  - 8 × (din0=1, din1=512) → dout=1.
  - 8 × (din0=-1, din1=512) → dout=0.
- Overflow: 8 × (din0=-32768, din1=32767) → dout=-32768 with TOP_FDCT_MAC_SAT_EN, dout=32 without.
- Stall: unity-gain stream with ce=0 for 3 cycles after input 5 → same dout=8000, out_valid delayed exactly 3 cycles, no extra pulse.
- Clear: 3 inputs (1000, 8192), then acc_clr with in_valid=1 plus 7 more identical inputs → single output 8000. A clear token alone after 3 inputs → no output.
- Mid-group reset: reset pulse after input 4 → out_valid/dout 0 at once. The next 8 inputs produce one correct result.
